// File: rtl/state_dump_scheduler.sv
// state_dump_scheduler: streams one 101-byte debug-state frame from the state-byte mux to the UART.
// Ports:
//   clk, rst          clock, async active-high reset
//   trigger           1-cycle frame request
//   auto_en           enable periodic requests every period_cfg cycles (0 = none)
//   section_mask      per-section enable, sampled at frame start (footer always sent)
//   byte_index        index into the state-byte mux; byte_in follows READ_LAT cycles later
//   tx_data/tx_valid  byte to the UART, held until tx_ready
//   busy              frame in progress
//   frame_done        pulse after the footer's last byte is accepted
//   frames_sent       wrapping count of completed frames
//   overrun           pulse when a request is dropped
module state_dump_scheduler #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period_cfg,
    input  logic [4:0]          section_mask,
    output logic [11:0]         byte_index,
    input  logic [7:0]          byte_in,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                frame_done,
    output logic [CNT_W-1:0]    frames_sent,
    output logic                overrun
);
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;
    state_t             state, state_n;
    logic [11:0]        byte_index_n;
    logic [7:0]         tx_data_n;
    logic               tx_valid_n, frame_done_n, overrun_n, pending, pending_n;
    logic [CNT_W-1:0]   frames_sent_n;
    logic [PERIOD_W-1:0] timer, timer_n;
    logic [4:0]         mask_q, mask_q_n;
    logic [LW-1:0]      lat, lat_n;
    logic               tick, req, launch;
    // Sections are contiguous, so skipping a disabled one lands exactly on the next section's start.
    function automatic logic [11:0] skip(input logic [11:0] i, input logic [4:0] m);
        logic [11:0] j;
        j = i;
        if (j == 12'd0  && !m[0]) j = 12'd6;
        if (j == 12'd6  && !m[1]) j = 12'd31;
        if (j == 12'd31 && !m[2]) j = 12'd68;
        if (j == 12'd68 && !m[3]) j = 12'd89;
        if (j == 12'd89 && !m[4]) j = 12'd97;
        return j;
    endfunction
    assign busy   = state != IDLE;
    assign tick   = auto_en && period_cfg != '0 && timer == period_cfg - 1'b1;
    assign req    = trigger || tick;
    // The frame_done cycle still counts as busy, so a queued frame launches one cycle later.
    assign launch = state == IDLE && !frame_done && (req || pending);
    always_comb begin
        state_n       = state;
        byte_index_n  = byte_index;
        tx_data_n     = tx_data;
        tx_valid_n    = tx_valid;
        frame_done_n  = 1'b0;
        overrun_n     = 1'b0;
        frames_sent_n = frames_sent;
        pending_n     = pending;
        mask_q_n      = mask_q;
        lat_n         = lat;
        timer_n       = (!auto_en || period_cfg == '0 || tick) ? '0 : timer + 1'b1;
        if (launch) pending_n = 1'b0;
        else if (req) begin
            overrun_n = pending;
            pending_n = 1'b1;
        end
        case (state)
            IDLE: if (launch) begin
                mask_q_n     = section_mask;
                byte_index_n = skip(12'd0, section_mask);
                lat_n        = '0;
                state_n      = FETCH;
            end
            FETCH: begin
                lat_n   = lat + 1'b1;
                state_n = (lat == LW'(READ_LAT - 1)) ? LOAD : FETCH;
            end
            LOAD: begin
                tx_data_n  = byte_in;
                tx_valid_n = 1'b1;
                state_n    = SEND;
            end
            SEND: if (tx_ready) begin
                tx_valid_n = 1'b0;
                lat_n      = '0;
                if (byte_index == 12'd100) begin
                    frame_done_n  = 1'b1;
                    frames_sent_n = frames_sent + 1'b1;
                    state_n       = IDLE;
                end else begin
                    byte_index_n = skip(byte_index + 12'd1, mask_q);
                    state_n      = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_index  <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            overrun     <= 1'b0;
            pending     <= 1'b0;
            timer       <= '0;
            mask_q      <= '0;
            lat         <= '0;
        end else begin
            state       <= state_n;
            byte_index  <= byte_index_n;
            tx_data     <= tx_data_n;
            tx_valid    <= tx_valid_n;
            frame_done  <= frame_done_n;
            frames_sent <= frames_sent_n;
            overrun     <= overrun_n;
            pending     <= pending_n;
            timer       <= timer_n;
            mask_q      <= mask_q_n;
            lat         <= lat_n;
        end
    end
endmodule

// File: tb/tb_state_dump_scheduler.sv
// tb_state_dump_scheduler: randomized bench with a frame-level reference model for state_dump_scheduler.
module tb_state_dump_scheduler;
    localparam int RL = 1;
    logic        clk, rst, trigger, auto_en, tx_ready, tx_valid, busy, frame_done, overrun;
    logic [23:0] period_cfg;
    logic [4:0]  section_mask;
    logic [11:0] byte_index;
    logic [7:0]  byte_in, tx_data;
    logic [15:0] frames_sent;
    state_dump_scheduler #(.PERIOD_W(24), .CNT_W(16), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .auto_en(auto_en), .period_cfg(period_cfg),
        .section_mask(section_mask), .byte_index(byte_index), .byte_in(byte_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
        .frames_sent(frames_sent), .overrun(overrun)
    );
    int total = 0, bad = 0, cyc = 0, fd_cnt = 0, ov_cnt = 0;
    logic [7:0] mem [0:100];
    logic [7:0] acc_d[$], t1_d[$];
    int         acc_i[$], acc_c[$], rise_c[$];
    bit         ready_mode = 0;
    // reference model state
    bit         m_busy, m_valid, m_fd, m_ov, m_pend;
    int         m_age, m_timer;
    logic [7:0] m_data;
    logic [15:0] m_sent;
    int         m_q[$];
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        for (int i = 0; i <= 100; i++) mem[i] = 8'(i * 7 + 3);
        for (int s = 0; s < 5; s++) begin
            int b;
            b = (s == 0) ? 0 : (s == 1) ? 6 : (s == 2) ? 31 : (s == 3) ? 68 : 89;
            mem[b] = 8'h0A; mem[b+1] = 8'h55; mem[b+2] = 8'hFA; mem[b+3] = 8'hCE; mem[b+4] = 8'(s + 1);
        end
        mem[97] = 8'hA2; mem[98] = 8'h5E; mem[99] = 8'hFA; mem[100] = 8'hCE;
    end
    always @(posedge clk) byte_in <= (byte_index <= 12'd100) ? mem[byte_index] : 8'h00;
    always @(posedge clk) cyc <= cyc + 1;
    initial forever begin
        @(posedge clk);
        #1 tx_ready = ready_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    function automatic int sec_of(input int i);
        return (i < 6) ? 0 : (i < 31) ? 1 : (i < 68) ? 2 : (i < 89) ? 3 : (i < 97) ? 4 : 5;
    endfunction
    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_fd = 0; m_ov = 0; m_pend = 0;
        m_age = 0; m_timer = 0; m_data = 0; m_sent = 0;
        m_q.delete();
    endtask
    // One clock of the spec's frame rules: request arbitration, then byte pacing from an index queue.
    task automatic model_step();
        bit tick, req, beff, launch, fd_n, ov_n;
        tick = auto_en && period_cfg != 0 && m_timer == int'(period_cfg) - 1;
        m_timer = (!auto_en || period_cfg == 0 || tick) ? 0 : m_timer + 1;
        req = trigger || tick;
        beff = m_busy || m_fd;
        launch = 0; fd_n = 0; ov_n = 0;
        if (req && beff) begin
            if (m_pend) ov_n = 1;
            else m_pend = 1;
        end else if (!beff && (req || m_pend)) begin
            launch = 1;
            m_pend = 0;
        end
        if (m_busy) begin
            if (m_valid) begin
                if (tx_ready) begin
                    m_valid = 0;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_busy = 0;
                        fd_n = 1;
                        m_sent++;
                    end else m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age == RL + 1) begin
                    m_valid = 1;
                    m_data = mem[m_q[0]];
                end
            end
        end else if (launch) begin
            for (int i = 0; i <= 100; i++) if (sec_of(i) == 5 || section_mask[sec_of(i)]) m_q.push_back(i);
            m_busy = 1;
            m_age = 0;
        end
        m_fd = fd_n;
        m_ov = ov_n;
    endtask
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end
    // Per-cycle comparison against the model plus passive monitors.
    initial begin
        bit prev_stall = 0, prev_busy = 0;
        logic [7:0] prev_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_busy = 0;
            end else begin
                chk("busy", 32'(busy), 32'(m_busy));
                chk("tx_valid", 32'(tx_valid), 32'(m_valid));
                chk("frame_done", 32'(frame_done), 32'(m_fd));
                chk("overrun", 32'(overrun), 32'(m_ov));
                chk("frames_sent", 32'(frames_sent), 32'(m_sent));
                if (m_valid) chk("tx_data", 32'(tx_data), 32'(m_data));
                if (m_busy) chk("byte_index", 32'(byte_index), 32'(m_q[0]));
                if (prev_stall) chk("hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
                if (tx_valid && tx_ready) begin
                    acc_d.push_back(tx_data);
                    acc_i.push_back(int'(byte_index));
                    acc_c.push_back(cyc);
                end
                if (frame_done) fd_cnt++;
                if (overrun) ov_cnt++;
                if (busy && !prev_busy) rise_c.push_back(cyc);
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
                prev_busy = busy;
            end
        end
    end
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_trigger();
        trigger = 1;
        cycles(1);
        trigger = 0;
    endtask
    task automatic clear_acc();
        acc_d.delete(); acc_i.delete(); acc_c.delete();
    endtask
    task automatic run_until_idle(input int maxc);
        int q = 0, n = 0;
        while (q < 4) begin
            @(negedge clk);
            n++;
            q = (!busy && !frame_done) ? q + 1 : 0;
            if (n > maxc) begin
                total++; bad++;
                $display("FAIL idle_timeout: still busy after %0d cycles", maxc);
                break;
            end
        end
        cycles(1);
    endtask
    initial begin
        int errs, s0, f0, n;
        rst = 1; trigger = 0; auto_en = 0; period_cfg = 0; section_mask = 0;
        cycles(3);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_index", 32'(byte_index), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_sent", 32'(frames_sent), 0);
        cycles(1);
        rst = 0;
        cycles(2);
        // full frame, ready always high
        clear_acc(); section_mask = 5'h1F; fd_cnt = 0;
        pulse_trigger();
        run_until_idle(1000);
        chk("t1_count", acc_d.size(), 101);
        if (acc_d.size() == 101) begin
            chk("t1_head", {acc_d[0], acc_d[1], acc_d[2], acc_d[3]}, 32'h0A55FACE);
            chk("t1_head4", 32'(acc_d[4]), 32'h01);
            chk("t1_tail", {acc_d[97], acc_d[98], acc_d[99], acc_d[100]}, 32'hA25EFACE);
            errs = 0;
            for (int i = 0; i < 101; i++) if (acc_i[i] != i) errs++;
            chk("t1_index_seq", errs, 0);
            errs = 0;
            for (int i = 1; i < 101; i++) if (acc_c[i] - acc_c[i-1] != RL + 2) errs++;
            chk("t1_spacing", errs, 0);
        end
        t1_d = acc_d;
        chk("t1_done_pulses", fd_cnt, 1);
        chk("t1_sent", 32'(frames_sent), 1);
        // footer only
        clear_acc(); section_mask = 5'h00;
        pulse_trigger();
        run_until_idle(200);
        chk("t2_count", acc_d.size(), 4);
        if (acc_d.size() == 4) begin
            chk("t2_bytes", {acc_d[0], acc_d[1], acc_d[2], acc_d[3]}, 32'hA25EFACE);
            chk("t2_first_idx", acc_i[0], 97);
        end
        // hashes only, mask changed mid-frame
        clear_acc(); section_mask = 5'h04;
        pulse_trigger();
        cycles(5);
        section_mask = 5'h1F;
        run_until_idle(500);
        chk("t3_count", acc_d.size(), 41);
        if (acc_d.size() == 41) begin
            chk("t3_head", {acc_d[0], acc_d[1], acc_d[2], acc_d[3]}, 32'h0A55FACE);
            chk("t3_head4", 32'(acc_d[4]), 32'h03);
            chk("t3_first_idx", acc_i[0], 31);
            chk("t3_footer_idx", acc_i[37], 97);
        end
        // random back-pressure
        clear_acc(); ready_mode = 1; section_mask = 5'h1F;
        pulse_trigger();
        run_until_idle(5000);
        ready_mode = 0;
        chk("t4_count", acc_d.size(), 101);
        errs = 0;
        if (acc_d.size() == 101) for (int i = 0; i < 101; i++) if (acc_d[i] != t1_d[i]) errs++;
        chk("t4_same_bytes", errs, 0);
        // periodic frames plus trigger queueing and overrun
        cycles(2);
        rise_c.delete(); s0 = int'(frames_sent); f0 = fd_cnt;
        period_cfg = 24'd400; auto_en = 1;
        n = 0;
        while (rise_c.size() < 2 && n < 1200) begin cycles(1); n++; end
        chk("t5_two_starts", rise_c.size() >= 2, 1);
        if (rise_c.size() >= 2) chk("t5_period", rise_c[1] - rise_c[0], 400);
        cycles(20);
        pulse_trigger();
        cycles(20);
        ov_cnt = 0;
        pulse_trigger();
        cycles(3);
        chk("t5_overrun", ov_cnt, 1);
        n = 0;
        while (rise_c.size() < 3 && n < 600) begin cycles(1); n++; end
        if (rise_c.size() >= 3) chk("t5_back_to_back", rise_c[2] - rise_c[1], 101 * (RL + 2) + 2);
        else chk("t5_third_start", rise_c.size(), 3);
        cycles(1500);
        auto_en = 0;
        run_until_idle(2000);
        chk("t5_sent_vs_done", int'(frames_sent) - s0, fd_cnt - f0);
        // randomized triggers, masks and back-pressure
        ready_mode = 1;
        for (int c = 0; c < 2500; c++) begin
            trigger = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) section_mask = 5'($urandom);
            cycles(1);
        end
        trigger = 0;
        run_until_idle(10000);
        ready_mode = 0;
        // reset in the middle of a frame
        section_mask = 5'h1F;
        cycles(2);
        pulse_trigger();
        n = 0;
        do begin @(negedge clk); n++; end while (!(byte_index == 12'd40 && tx_valid) && n < 1000);
        chk("t6_reach_idx40", n < 1000, 1);
        #1 rst = 1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_valid", 32'(tx_valid), 0);
        chk("t6_index", 32'(byte_index), 0);
        chk("t6_data", 32'(tx_data), 0);
        chk("t6_sent", 32'(frames_sent), 0);
        cycles(2);
        rst = 0;
        cycles(2);
        clear_acc();
        pulse_trigger();
        run_until_idle(1000);
        chk("t6_count", acc_d.size(), 101);
        if (acc_d.size() > 0) chk("t6_restart_idx", acc_i[0], 0);
        chk("t6_sent_after", 32'(frames_sent), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
